// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// cause codes and bus FSM state encoding.
package int_ctrl_pkg;

  localparam logic [1:0] INT_REG_PENDING = 2'd0;
  localparam logic [1:0] INT_REG_MASK    = 2'd1;
  localparam logic [1:0] INT_REG_CAUSE   = 2'd2;
  localparam logic [1:0] INT_REG_CTRL    = 2'd3;

  localparam int CAUSE_RAM      = 0;
  localparam int CAUSE_DISK     = 1;
  localparam int CAUSE_VRAM     = 2;
  localparam int CAUSE_KEYBOARD = 3;
  localparam int CAUSE_COUNTER  = 4;
  localparam int CAUSE_SWITCH   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_t;

endpackage

// File: rtl/int_ctrl_sync_edge.sv
// Per-source input stage: optional 2-flop synchroniser followed by a
// rising-edge detector producing a one-cycle pulse.
module int_sync_edge #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s2;
  logic prev;

  generate
    if (SYNC_EN) begin : g_sync
      logic s1;
      always_ff @(posedge clk) begin
        if (rst) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
        end else begin
          s1 <= din;
          s2 <= s1;
        end
      end
    end else begin : g_nosync
      // Single register keeps the edge detector on registered data even
      // when the source is already in this clock domain.
      always_ff @(posedge clk) begin
        if (rst) s2 <= 1'b0;
        else     s2 <= din;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= s2;
  end

  assign rise = s2 & ~prev;

endmodule

// File: rtl/int_ctrl.sv
// Wishbone-slave interrupt controller: sticky edge-triggered pending bits,
// software mask and global enable, lowest-index-first cause encoding.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC   = 6,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] clr;
  logic             gen;
  logic [1:0]       reg_sel;
  logic [31:0]      rd_data;
  logic             do_access;
  bus_state_t       state;
  bus_state_t       state_next;
  logic             unused_bits;

  generate
    for (genvar g = 0; g < N_SRC; g++) begin : g_src
      int_sync_edge #(.SYNC_EN(SYNC_EN)) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (irq_in[g]),
        .rise (rise[g])
      );
    end
  endgenerate

  assign reg_sel     = ADDR[3:2];
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I};

  // Lowest set bit of the enabled pending set wins; GEN only gates INT.
  always_comb begin
    active = pending & mask;
    CAUSE  = 32'h0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) CAUSE = 32'(i);
    end
    INT = gen & (|active);
  end

  always_comb begin
    state_next = state;
    do_access  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (STB) begin
          do_access  = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_WAIT;
      ST_WAIT: if (!STB) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    case (reg_sel)
      INT_REG_PENDING: rd_data = 32'(pending);
      INT_REG_MASK:    rd_data = 32'(mask);
      INT_REG_CAUSE:   rd_data = CAUSE;
      INT_REG_CTRL:    rd_data = {31'h0, gen};
      default:         rd_data = 32'h0;
    endcase
    clr = (do_access && WE && reg_sel == INT_REG_PENDING) ? DAT_I[N_SRC-1:0] : '0;
  end

  assign ACK = (state == ST_ACK);

  // Set is OR-ed in after the clear so a coincident edge is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      mask    <= '0;
      gen     <= 1'b0;
      DAT_O   <= 32'h0;
    end else begin
      state   <= state_next;
      pending <= (pending & ~clr) | rise;
      if (do_access && !WE) DAT_O <= rd_data;
      if (do_access && WE) begin
        if (reg_sel == INT_REG_MASK) mask <= DAT_I[N_SRC-1:0];
        if (reg_sel == INT_REG_CTRL) gen  <= DAT_I[0];
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios followed by random
// interrupt traffic, compared against a behavioural pending/mask model.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq_in;
  logic        STB, WE;
  logic [31:0] ADDR, DAT_I, DAT_O, CAUSE;
  logic        ACK, INT;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: samples of irq_in at the last three edges, and register state.
  logic [5:0] h0 = '0, h1 = '0, h2 = '0;
  logic [5:0] m_pending = '0, m_mask = '0;
  logic       m_gen = 1'b0;
  logic [5:0] req_clr = '0, req_mask = '0;
  logic       req_mask_v = 1'b0, req_gen_v = 1'b0, req_gen = 1'b0;
  logic       exp_ack = 1'b0;
  logic [31:0] rd_val;

  int_ctrl #(.N_SRC(6), .SYNC_EN(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .STB    (STB),
    .WE     (WE),
    .ADDR   (ADDR),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .ACK    (ACK),
    .INT    (INT),
    .CAUSE  (CAUSE)
  );

  always #5 clk = ~clk;

  // A rising edge seen on irq_in lands in pending two edges after it is sampled.
  always @(posedge clk) begin
    if (rst) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
      m_pending <= '0; m_mask <= '0; m_gen <= 1'b0;
    end else begin
      m_pending <= (m_pending & ~req_clr) | (h1 & ~h2);
      if (req_mask_v) m_mask <= req_mask;
      if (req_gen_v)  m_gen  <= req_gen;
      h2 <= h1; h1 <= h0; h0 <= irq_in;
    end
  end

  function automatic logic [31:0] model_cause();
    logic [5:0] act;
    act = m_pending & m_mask;
    for (int i = 0; i < 6; i++) if (act[i]) return 32'(i);
    return 32'h0;
  endfunction

  function automatic logic model_int();
    return m_gen & (|(m_pending & m_mask));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("ack", {31'h0, ACK}, {31'h0, exp_ack});
    check("int", {31'h0, INT}, {31'h0, model_int()});
    check("cause", CAUSE, model_cause());
  endtask

  task automatic clear_reqs();
    req_clr = '0; req_mask_v = 1'b0; req_gen_v = 1'b0;
  endtask

  task automatic start_access(input logic [1:0] sel, input logic we, input logic [31:0] data);
    logic [31:0] a;
    a = $urandom;
    a[3:2] = sel;
    ADDR = a; WE = we; DAT_I = data; STB = 1'b1;
    if (we) begin
      case (sel)
        INT_REG_PENDING: req_clr = data[5:0];
        INT_REG_MASK:    begin req_mask_v = 1'b1; req_mask = data[5:0]; end
        INT_REG_CTRL:    begin req_gen_v = 1'b1;  req_gen  = data[0];   end
        default: ;
      endcase
    end
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [31:0] data);
    start_access(sel, 1'b1, data);
    exp_ack = 1'b1;
    tick();
    clear_reqs();
    exp_ack = 1'b0;
    STB = 1'b0; WE = 1'b0;
    tick();
    tick();
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [31:0] data);
    logic [31:0] exp;
    case (sel)
      INT_REG_PENDING: exp = 32'(m_pending);
      INT_REG_MASK:    exp = 32'(m_mask);
      INT_REG_CAUSE:   exp = model_cause();
      default:         exp = {31'h0, m_gen};
    endcase
    start_access(sel, 1'b0, $urandom);
    exp_ack = 1'b1;
    tick();
    data = DAT_O;
    check($sformatf("read_reg%0d", sel), DAT_O, exp);
    exp_ack = 1'b0;
    STB = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
    repeat (3) tick();
    check("reset_dat_o", DAT_O, 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] reset register reads");
    for (int r = 0; r < 4; r++) begin
      bus_read(2'(r), rd_val);
      check("reset_read_zero", rd_val, 32'h0);
    end

    $display("[TB] single source, mask and W1C");
    bus_write(INT_REG_MASK, 32'h08);
    bus_write(INT_REG_CTRL, 32'h1);
    irq_in[3] = 1'b1; tick();
    irq_in[3] = 1'b0; tick(); tick();
    check("kbd_int", {31'h0, INT}, 32'h1);
    check("kbd_cause", CAUSE, 32'(CAUSE_KEYBOARD));
    bus_write(INT_REG_PENDING, 32'h8);
    check("kbd_cleared", {31'h0, INT}, 32'h0);

    $display("[TB] priority between two sources");
    bus_write(INT_REG_MASK, 32'h3F);
    irq_in = 6'b010010; tick();
    irq_in = '0; repeat (3) tick();
    check("prio_disk", CAUSE, 32'(CAUSE_DISK));
    bus_write(INT_REG_PENDING, 32'h2);
    check("prio_counter", CAUSE, 32'(CAUSE_COUNTER));
    bus_write(INT_REG_PENDING, 32'h10);
    check("prio_none_cause", CAUSE, 32'h0);
    check("prio_none_int", {31'h0, INT}, 32'h0);

    $display("[TB] level held high gives a single event");
    irq_in[2] = 1'b1;
    repeat (50) tick();
    bus_read(INT_REG_PENDING, rd_val);
    check("held_once", rd_val, 32'h4);
    bus_write(INT_REG_PENDING, 32'h4);
    bus_read(INT_REG_PENDING, rd_val);
    check("held_after_clear", rd_val, 32'h0);
    irq_in[2] = 1'b0; tick();
    irq_in[2] = 1'b1; repeat (4) tick();
    bus_read(INT_REG_PENDING, rd_val);
    check("held_new_edge", rd_val, 32'h4);
    irq_in[2] = 1'b0;
    bus_write(INT_REG_PENDING, 32'h4);

    $display("[TB] set beats coincident clear");
    irq_in[0] = 1'b1; tick(); tick();
    bus_write(INT_REG_PENDING, 32'h1);
    bus_read(INT_REG_PENDING, rd_val);
    check("set_wins", rd_val, 32'h1);
    irq_in[0] = 1'b0;
    bus_write(INT_REG_PENDING, 32'h1);

    $display("[TB] long strobe, single ack");
    start_access(INT_REG_MASK, 1'b1, 32'h15);
    exp_ack = 1'b1;
    tick();
    clear_reqs();
    exp_ack = 1'b0;
    repeat (4) tick();
    STB = 1'b0; WE = 1'b0;
    tick(); tick();
    bus_read(INT_REG_MASK, rd_val);
    check("long_strobe_mask", rd_val, 32'h15);

    $display("[TB] reset during ack");
    start_access(INT_REG_MASK, 1'b1, 32'h3F);
    exp_ack = 1'b1;
    tick();
    clear_reqs();
    exp_ack = 1'b0;
    rst = 1'b1; STB = 1'b0; WE = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus_read(INT_REG_MASK, rd_val);
    check("rst_ack_mask", rd_val, 32'h0);

    $display("[TB] random traffic");
    bus_write(INT_REG_CTRL, 32'h1);
    bus_write(INT_REG_MASK, 32'h3F);
    for (int c = 0; c < 300; c++) begin
      irq_in = irq_in ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
      tick();
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 4))
          0: bus_write(INT_REG_PENDING, $urandom);
          1: bus_write(INT_REG_MASK, $urandom);
          2: bus_write(2'($urandom_range(2, 3)), $urandom);
          default: bus_read(2'($urandom_range(0, 3)), rd_val);
        endcase
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
